// File: rtl/dtcm_arbiter_pkg.sv
// rtl/dtcm_arbiter_pkg.sv - shared state encodings and port ids for the DTCM arbiter
package dtcm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RSP  = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state_e;

  localparam logic P_LSU = 1'b0;
  localparam logic P_EXT = 1'b1;

endpackage

// File: rtl/dtcm_arbiter_rr_arb2.sv
// rtl/dtcm_arbiter_rr_arb2.sv - two-way round-robin grant with last-winner register
module dtcm_arbiter_rr_arb2
  import dtcm_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic rr_last;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr_last == P_EXT) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= P_EXT;
    end else if (update) begin
      rr_last <= grant[1];
    end
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// rtl/dtcm_arbiter.sv - two-port round-robin arbiter and sequencer for the single-port DTCM RAM
module dtcm_arbiter
  import dtcm_arbiter_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_cmd_valid,
  output logic          p0_cmd_ready,
  input  logic          p0_cmd_read,
  input  logic [AW-1:0] p0_cmd_addr,
  input  logic [DW-1:0] p0_cmd_wdata,
  input  logic [MW-1:0] p0_cmd_wmask,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_cmd_valid,
  output logic          p1_cmd_ready,
  input  logic          p1_cmd_read,
  input  logic [AW-1:0] p1_cmd_addr,
  input  logic [DW-1:0] p1_cmd_wdata,
  input  logic [MW-1:0] p1_cmd_wmask,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  arb_state_e    state;
  logic          owner;
  logic          is_read;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [MW-1:0] wem_q;

  logic [1:0]    req;
  logic [1:0]    grant;
  logic          busy;
  logic          owner_rsp_ready;
  logic          rsp_hs;
  logic          can_issue;
  logic          cmd_hs;
  logic          sel;
  logic          sel_read;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;
  logic [DW-1:0] rsp_data;

  assign req = {p1_cmd_valid, p0_cmd_valid};

  dtcm_arbiter_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (cmd_hs),
    .grant  (grant)
  );

  assign busy            = (state != ARB_IDLE);
  assign owner_rsp_ready = (owner == P_EXT) ? p1_rsp_ready : p0_rsp_ready;
  assign rsp_hs          = busy & owner_rsp_ready;
  // Holding off issue during reset keeps the RAM free of writes while rst is high.
  assign can_issue       = ~rst & (~busy | rsp_hs);
  assign cmd_hs          = can_issue & (|req);

  assign p0_cmd_ready = can_issue & grant[0];
  assign p1_cmd_ready = can_issue & grant[1];

  assign sel       = grant[1];
  assign sel_read  = sel ? p1_cmd_read  : p0_cmd_read;
  assign sel_addr  = sel ? p1_cmd_addr  : p0_cmd_addr;
  assign sel_wdata = sel ? p1_cmd_wdata : p0_cmd_wdata;
  assign sel_wmask = sel ? p1_cmd_wmask : p0_cmd_wmask;

  assign ram_we   = cmd_hs & ~sel_read;
  assign ram_addr = cmd_hs ? sel_addr  : addr_q;
  assign ram_din  = cmd_hs ? sel_wdata : din_q;
  assign ram_wem  = cmd_hs ? sel_wmask : wem_q;

  // First response cycle bypasses the RAM output; later cycles replay the captured word.
  assign rsp_data = ~is_read            ? '0       :
                    (state == ARB_RSP)  ? ram_dout : rdata_q;

  assign p0_rsp_valid = busy & (owner == P_LSU);
  assign p1_rsp_valid = busy & (owner == P_EXT);
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      owner   <= P_LSU;
      is_read <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wem_q   <= '0;
    end else begin
      if (state == ARB_RSP) begin
        rdata_q <= ram_dout;
      end
      if (cmd_hs) begin
        owner   <= sel;
        is_read <= sel_read;
        addr_q  <= sel_addr;
        din_q   <= sel_wdata;
        wem_q   <= sel_wmask;
      end
      if (cmd_hs) begin
        state <= ARB_RSP;
      end else if (!busy || rsp_hs) begin
        state <= ARB_IDLE;
      end else begin
        state <= ARB_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// tb/tb_dtcm_arbiter.sv - directed self-checking bench for dtcm_arbiter
module tb_dtcm_arbiter;
  import dtcm_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        p0_cmd_valid, p0_cmd_ready, p0_cmd_read;
  logic [13:0] p0_cmd_addr;
  logic [31:0] p0_cmd_wdata;
  logic [3:0]  p0_cmd_wmask;
  logic        p0_rsp_valid, p0_rsp_ready;
  logic [31:0] p0_rsp_rdata;
  logic        p1_cmd_valid, p1_cmd_ready, p1_cmd_read;
  logic [13:0] p1_cmd_addr;
  logic [31:0] p1_cmd_wdata;
  logic [3:0]  p1_cmd_wmask;
  logic        p1_rsp_valid, p1_rsp_ready;
  logic [31:0] p1_rsp_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:16383];
  logic [31:0] ram_q;
  logic        init_mem;
  logic        force_en;
  logic [31:0] force_val;

  int checks = 0;
  int failures = 0;

  dtcm_arbiter #(.AW(14), .DW(32), .MW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_cmd_valid (p0_cmd_valid),
    .p0_cmd_ready (p0_cmd_ready),
    .p0_cmd_read  (p0_cmd_read),
    .p0_cmd_addr  (p0_cmd_addr),
    .p0_cmd_wdata (p0_cmd_wdata),
    .p0_cmd_wmask (p0_cmd_wmask),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (p0_rsp_ready),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_cmd_valid (p1_cmd_valid),
    .p1_cmd_ready (p1_cmd_ready),
    .p1_cmd_read  (p1_cmd_read),
    .p1_cmd_addr  (p1_cmd_addr),
    .p1_cmd_wdata (p1_cmd_wdata),
    .p1_cmd_wmask (p1_cmd_wmask),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (p1_rsp_ready),
    .p1_rsp_rdata (p1_rsp_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_wem      (ram_wem),
    .ram_dout     (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    if (a == 16) return 32'hDEADBEEF;
    if (a >= 64 && a < 96) return 32'hC0DE0000 | 32'(a);
    return 32'h0;
  endfunction

  // Synchronous RAM: registered read, byte-masked write.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int a = 0; a < 128; a++) mem[a] <= init_word(a);
    end else begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
      ram_q <= mem[ram_addr];
    end
  end

  assign ram_dout = force_en ? force_val : ram_q;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_mem = 1'b1; force_en = 1'b0; force_val = '0;
    p0_cmd_valid = 0; p0_cmd_read = 0; p0_cmd_addr = '0; p0_cmd_wdata = '0; p0_cmd_wmask = '0;
    p1_cmd_valid = 0; p1_cmd_read = 0; p1_cmd_addr = '0; p1_cmd_wdata = '0; p1_cmd_wmask = '0;
    p0_rsp_ready = 0; p1_rsp_ready = 0;

    tick();
    init_mem = 1'b0;
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 14'h10;
    tick();
    settle();
    check_eq("rst_p0_cmd_ready", 32'(p0_cmd_ready), 32'd0);
    check_eq("rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
    check_eq("rst_p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_p0_rdata", p0_rsp_rdata, 32'd0);

    // single read from port 0
    tick();
    rst = 1'b0; p0_rsp_ready = 1; p1_rsp_ready = 1;
    settle();
    check_eq("t1_p0_cmd_ready", 32'(p0_cmd_ready), 32'd1);
    check_eq("t1_ram_addr", 32'(ram_addr), 32'h10);
    check_eq("t1_ram_we", 32'(ram_we), 32'd0);
    tick();
    p0_cmd_valid = 0;
    settle();
    check_eq("t1_p0_rsp_valid", 32'(p0_rsp_valid), 32'd1);
    check_eq("t1_p0_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    check_eq("t1_p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
    tick();
    settle();
    check_eq("t1_idle_rsp_valid", 32'(p0_rsp_valid), 32'd0);
    check_eq("t1_idle_state", 32'(dut.state), 32'(ARB_IDLE));

    // both ports stream reads: grants alternate starting at port 0
    tick();
    do_reset();
    p0_cmd_valid = 1; p0_cmd_read = 1; p1_cmd_valid = 1; p1_cmd_read = 1;
    for (int k = 0; k < 6; k++) begin
      p0_cmd_addr = 14'h40 + 14'((k + 1) / 2);
      p1_cmd_addr = 14'h50 + 14'(k / 2);
      settle();
      check_eq($sformatf("t2_p0_ready_%0d", k), 32'(p0_cmd_ready), 32'(k % 2 == 0));
      check_eq($sformatf("t2_p1_ready_%0d", k), 32'(p1_cmd_ready), 32'(k % 2 == 1));
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          check_eq($sformatf("t2_p0_rvalid_%0d", k), 32'(p0_rsp_valid), 32'd1);
          check_eq($sformatf("t2_p0_rdata_%0d", k), p0_rsp_rdata, 32'hC0DE0040 + 32'((k - 1) / 2));
          check_eq($sformatf("t2_p1_rvalid_%0d", k), 32'(p1_rsp_valid), 32'd0);
        end else begin
          check_eq($sformatf("t2_p1_rvalid_%0d", k), 32'(p1_rsp_valid), 32'd1);
          check_eq($sformatf("t2_p1_rdata_%0d", k), p1_rsp_rdata, 32'hC0DE0050 + 32'((k - 1) / 2));
          check_eq($sformatf("t2_p0_rvalid_%0d", k), 32'(p0_rsp_valid), 32'd0);
        end
      end
      tick();
    end
    p0_cmd_valid = 0; p1_cmd_valid = 0;
    settle();
    check_eq("t2_last_p1_rvalid", 32'(p1_rsp_valid), 32'd1);
    check_eq("t2_last_p1_rdata", p1_rsp_rdata, 32'hC0DE0052);
    check_eq("t2_last_p0_rdata", p0_rsp_rdata, 32'd0);
    tick();

    // port 1 masked write, then port 0 reads it back
    p1_cmd_valid = 1; p1_cmd_read = 0; p1_cmd_addr = 14'h20;
    p1_cmd_wdata = 32'h12345678; p1_cmd_wmask = 4'b0011;
    settle();
    check_eq("t3_p1_cmd_ready", 32'(p1_cmd_ready), 32'd1);
    check_eq("t3_ram_we", 32'(ram_we), 32'd1);
    check_eq("t3_ram_addr", 32'(ram_addr), 32'h20);
    check_eq("t3_ram_wem", 32'(ram_wem), 32'h3);
    check_eq("t3_ram_din", ram_din, 32'h12345678);
    tick();
    p1_cmd_valid = 0;
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 14'h20;
    settle();
    check_eq("t3_wack_valid", 32'(p1_rsp_valid), 32'd1);
    check_eq("t3_wack_rdata", p1_rsp_rdata, 32'd0);
    check_eq("t3_p0_cmd_ready", 32'(p0_cmd_ready), 32'd1);
    check_eq("t3_ram_we_read", 32'(ram_we), 32'd0);
    tick();
    p0_cmd_valid = 0;
    settle();
    check_eq("t3_p0_rvalid", 32'(p0_rsp_valid), 32'd1);
    check_eq("t3_p0_rdata", p0_rsp_rdata, 32'h00005678);
    tick();

    // port 0 read stalled by rsp_ready while port 1 waits
    p0_rsp_ready = 0;
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 14'h10;
    settle();
    check_eq("t4_p0_cmd_ready", 32'(p0_cmd_ready), 32'd1);
    tick();
    p0_cmd_valid = 0;
    p1_cmd_valid = 1; p1_cmd_read = 1; p1_cmd_addr = 14'h41;
    for (int h = 0; h < 4; h++) begin
      settle();
      check_eq($sformatf("t4_rvalid_%0d", h), 32'(p0_rsp_valid), 32'd1);
      check_eq($sformatf("t4_rdata_%0d", h), p0_rsp_rdata, 32'hDEADBEEF);
      check_eq($sformatf("t4_p1_ready_%0d", h), 32'(p1_cmd_ready), 32'(h == 3));
      tick();
      if (h < 3) begin
        force_en = 1; force_val = 32'h55550000 + 32'(h);
        if (h == 2) p0_rsp_ready = 1;
      end else begin
        force_en = 0; p1_cmd_valid = 0;
      end
    end
    settle();
    check_eq("t4_p1_rvalid", 32'(p1_rsp_valid), 32'd1);
    check_eq("t4_p1_rdata", p1_rsp_rdata, 32'hC0DE0041);
    check_eq("t4_p0_rvalid_off", 32'(p0_rsp_valid), 32'd0);
    tick();

    // reset in the cycle after a handshake
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 14'h10;
    settle();
    check_eq("t5_p0_cmd_ready", 32'(p0_cmd_ready), 32'd1);
    tick();
    p0_cmd_valid = 0; rst = 1;
    p1_cmd_valid = 1; p1_cmd_read = 0; p1_cmd_addr = 14'h60;
    p1_cmd_wdata = 32'hFFFFFFFF; p1_cmd_wmask = 4'hF;
    settle();
    check_eq("t5_rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("t5_rst_p1_ready", 32'(p1_cmd_ready), 32'd0);
    tick();
    rst = 0;
    p0_cmd_valid = 1;
    settle();
    check_eq("t5_post_rvalid", 32'(p0_rsp_valid), 32'd0);
    check_eq("t5_post_p0_ready", 32'(p0_cmd_ready), 32'd1);
    check_eq("t5_post_p1_ready", 32'(p1_cmd_ready), 32'd0);
    check_eq("t5_post_ram_we", 32'(ram_we), 32'd0);
    tick();
    p0_cmd_valid = 0; p1_cmd_valid = 0;
    settle();
    check_eq("t5_p0_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    tick();

    // back-to-back write then read of the same word
    p0_cmd_valid = 1; p0_cmd_read = 0; p0_cmd_addr = 14'h30;
    p0_cmd_wdata = 32'hCAFEF00D; p0_cmd_wmask = 4'hF;
    settle();
    check_eq("t6_wr_ram_we", 32'(ram_we), 32'd1);
    check_eq("t6_wr_ready", 32'(p0_cmd_ready), 32'd1);
    tick();
    p0_cmd_read = 1;
    settle();
    check_eq("t6_rd_ram_we", 32'(ram_we), 32'd0);
    check_eq("t6_rd_ready", 32'(p0_cmd_ready), 32'd1);
    check_eq("t6_wack_valid", 32'(p0_rsp_valid), 32'd1);
    check_eq("t6_wack_rdata", p0_rsp_rdata, 32'd0);
    tick();
    p0_cmd_valid = 0;
    settle();
    check_eq("t6_rd_rvalid", 32'(p0_rsp_valid), 32'd1);
    check_eq("t6_rd_rdata", p0_rsp_rdata, 32'hCAFEF00D);
    check_eq("t6_idle_ram_we", 32'(ram_we), 32'd0);
    tick();
    settle();
    check_eq("t6_end_rvalid", 32'(p0_rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
